// File: rtl/gameboy_pkg.sv
// Shared encodings for the gameboy character core and its pad arbiter.
// Button, mode, action and arbiter-state codes live here so both sides agree.
package gameboy_pkg;

    typedef enum logic [1:0] {
        BTN_FIGHT = 2'd0,
        BTN_REACT = 2'd1,
        BTN_A     = 2'd2,
        BTN_B     = 2'd3
    } btn_e;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_FIGHT = 2'd1,
        MODE_REACT = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ACT_KICK  = 3'b000,
        ACT_PUNCH = 3'b001,
        ACT_JUMP  = 3'b010,
        ACT_DUCK  = 3'b011,
        ACT_RUN   = 3'b100
    } action_e;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_LOCK = 2'd1,
        ST_EXIT = 2'd2
    } arb_state_e;

    // Button that enters (and leaves) a given locked mode.
    function automatic btn_e mode_btn(input mode_e m);
        return (m == MODE_REACT) ? BTN_REACT : BTN_FIGHT;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Owner-idle counter for a locked mode; expire marks the last idle cycle
// before the arbiter must inject the exit press itself.
module lock_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Never wraps: the arbiter leaves LOCK on the cycle this fires.
    assign expire = run && !clear && (cnt_q == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pad_arbiter.sv
// Shares the character core between two pads: round-robin while idle, exclusive
// ownership while in FIGHT/REACT, with a forced exit after the owner goes idle.
module pad_arbiter
    import gameboy_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_btn0,
    input  logic [1:0] req_btn1,
    output logic [1:0] req_ready,
    output logic [1:0] core_btn,
    output logic       core_en,
    output logic [1:0] mode,
    output logic       locked,
    output logic       owner
);

    arb_state_e state_q, state_d;
    mode_e      mode_q, mode_d;
    logic       rr_q, rr_d;
    logic       owner_q, owner_d;
    logic       core_en_q, core_en_d;
    logic [1:0] core_btn_q, core_btn_d;

    logic       xfer;
    logic       gidx;
    logic [1:0] pbtn;
    logic       expire;
    logic       strobe_src;

    always_comb begin
        req_ready = '0;
        if (reset) begin
            case (state_q)
                ST_ARB: begin
                    if (&req_valid) begin
                        req_ready = rr_q ? 2'b10 : 2'b01;
                    end else begin
                        req_ready = req_valid;
                    end
                end
                ST_LOCK: req_ready[owner_q] = req_valid[owner_q];
                default: req_ready = '0;
            endcase
        end
    end

    assign xfer = |req_ready;
    assign gidx = req_ready[1];
    assign pbtn = gidx ? req_btn1 : req_btn0;

    lock_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  ((state_q != ST_LOCK) || xfer),
        .run    (state_q == ST_LOCK),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        core_en_d  = 1'b0;
        core_btn_d = core_btn_q;
        case (state_q)
            ST_ARB: begin
                if (xfer) begin
                    core_en_d  = 1'b1;
                    core_btn_d = pbtn;
                    rr_d       = ~gidx;
                    if (pbtn == BTN_FIGHT) begin
                        mode_d  = MODE_FIGHT;
                        owner_d = gidx;
                        state_d = ST_LOCK;
                    end else if (pbtn == BTN_REACT) begin
                        mode_d  = MODE_REACT;
                        owner_d = gidx;
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    if (pbtn == mode_btn(mode_q)) begin
                        core_en_d  = 1'b1;
                        core_btn_d = pbtn;
                        mode_d     = MODE_IDLE;
                        rr_d       = ~owner_q;
                        state_d    = ST_ARB;
                    end else if (pbtn == BTN_A || pbtn == BTN_B) begin
                        core_en_d  = 1'b1;
                        core_btn_d = pbtn;
                    end
                    // Cross-mode press is consumed without reaching the core.
                end else if (expire) begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                core_en_d  = 1'b1;
                core_btn_d = mode_btn(mode_q);
                mode_d     = MODE_IDLE;
                rr_d       = ~owner_q;
                state_d    = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ARB;
            mode_q     <= MODE_IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            core_en_q  <= 1'b0;
            core_btn_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            core_en_q  <= core_en_d;
            core_btn_q <= core_btn_d;
        end
    end

    assign core_btn = core_btn_q;
    assign core_en  = core_en_q;
    assign mode     = mode_q;
    assign locked   = (mode_q != MODE_IDLE);
    assign owner    = owner_q;

    // A strobe originates from a pad transfer or from the injected exit press.
    assign strobe_src = xfer || (state_q == ST_EXIT);

    ap_ready_onehot: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(req_ready));

    ap_en_pair: assert property (@(posedge clock) disable iff (!reset)
        (core_en_q && $past(core_en_q)) |-> ($past(strobe_src) && $past(strobe_src, 2)));

endmodule

// File: tb/tb_pad_arbiter.sv
// Bench for pad_arbiter: directed scenarios with literal expectations, then
// randomized pad traffic checked every cycle against a rule-level model.
module tb_pad_arbiter;

    localparam int TIMEOUT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_btn0 = 2'd0;
    logic [1:0] req_btn1 = 2'd0;
    logic [1:0] req_ready;
    logic [1:0] core_btn;
    logic       core_en;
    logic [1:0] mode;
    logic       locked;
    logic       owner;

    pad_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_btn0  (req_btn0),
        .req_btn1  (req_btn1),
        .req_ready (req_ready),
        .core_btn  (core_btn),
        .core_en   (core_en),
        .mode      (mode),
        .locked    (locked),
        .owner     (owner)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0/1/2, owning pad, round-robin pad, idle cycles seen,
    // pending forced exit, and the last strobe the core should have received.
    int   m_mode, m_owner, m_rr, m_idle, m_btn;
    bit   m_exit, m_en;
    logic [1:0] exp_rdy;
    bit   m_xfer;
    int   m_g, m_b;

    always @(negedge clock) begin
        if (!reset) begin
            m_mode = 0; m_owner = 0; m_rr = 0; m_idle = 0; m_btn = 0;
            m_exit = 0; m_en = 0;
            chk("rst_ready", req_ready, 0);
            chk("rst_core_en", core_en, 0);
            chk("rst_core_btn", core_btn, 0);
            chk("rst_mode", mode, 0);
            chk("rst_locked", locked, 0);
            chk("rst_owner", owner, 0);
        end else begin
            if (m_exit) begin
                exp_rdy = 2'b00;
            end else if (m_mode != 0) begin
                exp_rdy = 2'b00;
                exp_rdy[m_owner] = req_valid[m_owner];
            end else if (req_valid == 2'b11) begin
                exp_rdy = (m_rr == 1) ? 2'b10 : 2'b01;
            end else begin
                exp_rdy = req_valid;
            end

            chk("req_ready", req_ready, exp_rdy);
            chk("core_en", core_en, m_en);
            if (m_en) chk("core_btn", core_btn, m_btn);
            chk("mode", mode, m_mode);
            chk("locked", locked, (m_mode != 0) ? 1 : 0);
            if (m_mode != 0) chk("owner", owner, m_owner);

            m_xfer = (exp_rdy != 2'b00);
            m_g    = exp_rdy[1] ? 1 : 0;
            m_b    = (m_g == 1) ? int'(req_btn1) : int'(req_btn0);
            m_en   = 0;
            if (m_exit) begin
                m_en   = 1;
                m_btn  = (m_mode == 1) ? 0 : 1;
                m_mode = 0;
                m_rr   = 1 - m_owner;
                m_exit = 0;
            end else if (m_mode == 0) begin
                if (m_xfer) begin
                    m_en  = 1;
                    m_btn = m_b;
                    m_rr  = 1 - m_g;
                    if (m_b < 2) begin
                        m_mode  = m_b + 1;
                        m_owner = m_g;
                        m_idle  = 0;
                    end
                end
            end else if (m_xfer) begin
                m_idle = 0;
                if (m_b == m_mode - 1) begin
                    m_en   = 1;
                    m_btn  = m_b;
                    m_mode = 0;
                    m_rr   = 1 - m_owner;
                end else if (m_b >= 2) begin
                    m_en  = 1;
                    m_btn = m_b;
                end
            end else if (m_idle == TIMEOUT - 1) begin
                m_exit = 1;
            end else begin
                m_idle++;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    logic [1:0] pv;
    logic [1:0] pb [2];
    logic [1:0] rdy_s;
    int         rate;

    initial begin
        // Reset, then a lone A press from P0.
        cyc(); cyc();
        req_valid = 2'b11; req_btn0 = 2'd2; req_btn1 = 2'd2;
        #1;
        chk("in_reset_ready", req_ready, 0);
        chk("in_reset_mode", mode, 0);
        chk("in_reset_en", core_en, 0);
        req_valid = 2'b01; reset = 1'b1;
        #1;
        chk("a_ready", req_ready, 1);
        cyc(); req_valid = 2'b00;
        chk("a_core_btn", core_btn, 2);
        chk("a_core_en", core_en, 1);
        chk("a_mode", mode, 0);
        chk("a_locked", locked, 0);
        cyc();
        chk("a_en_low", core_en, 0);

        // Both pads press B right after reset: P0 then P1.
        reset = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        cyc(); req_valid = 2'b11; req_btn0 = 2'd3; req_btn1 = 2'd3;
        #1 chk("bb_ready0", req_ready, 1);
        cyc(); req_valid = 2'b10;
        #1;
        chk("bb_ready1", req_ready, 2);
        chk("bb_en0", core_en, 1);
        chk("bb_btn0", core_btn, 3);
        cyc(); req_valid = 2'b00;
        #1;
        chk("bb_en1", core_en, 1);
        chk("bb_btn1", core_btn, 3);
        cyc();
        chk("bb_en_low", core_en, 0);

        // P1 locks FIGHT; P0 waits until P1 leaves.
        cyc(); req_valid = 2'b10; req_btn1 = 2'd0;
        #1 chk("f_ready", req_ready, 2);
        cyc(); req_valid = 2'b01; req_btn0 = 2'd2;
        #1;
        chk("f_mode", mode, 1);
        chk("f_owner", owner, 1);
        chk("f_locked", locked, 1);
        chk("f_p0_held", req_ready, 0);
        cyc(); req_valid = 2'b11; req_btn1 = 2'd0;
        #1 chk("f_exit_ready", req_ready, 2);
        cyc(); req_valid = 2'b01;
        #1;
        chk("f_left_mode", mode, 0);
        chk("f_left_btn", core_btn, 0);
        chk("f_left_en", core_en, 1);
        chk("f_p0_granted", req_ready, 1);
        cyc(); req_valid = 2'b00;
        #1 chk("f_p0_btn", core_btn, 2);

        // P0 locks REACT and goes idle: forced exit.
        cyc(); req_valid = 2'b01; req_btn0 = 2'd1;
        #1 chk("r_ready", req_ready, 1);
        cyc(); req_valid = 2'b00;
        #1;
        chk("r_mode", mode, 2);
        chk("r_owner", owner, 0);
        repeat (3) cyc();
        #1;
        chk("r_still_locked", mode, 2);
        chk("r_no_strobe", core_en, 0);
        cyc(); req_valid = 2'b01; req_btn0 = 2'd2;
        #1;
        chk("r_exit_ready", req_ready, 0);
        chk("r_exit_mode", mode, 2);
        cyc(); req_valid = 2'b11; req_btn1 = 2'd2;
        #1;
        chk("r_inject_btn", core_btn, 1);
        chk("r_inject_en", core_en, 1);
        chk("r_inject_mode", mode, 0);
        chk("r_inject_locked", locked, 0);
        chk("r_rr_p1", req_ready, 2);
        cyc(); req_valid = 2'b01;
        #1 chk("r_then_p0", req_ready, 1);
        cyc(); req_valid = 2'b00;

        // FIGHT owner presses React on the last idle cycle: dropped, no exit.
        cyc(); req_valid = 2'b01; req_btn0 = 2'd0;
        #1 chk("x_ready", req_ready, 1);
        cyc(); req_valid = 2'b00;
        #1 chk("x_mode", mode, 1);
        repeat (3) cyc();
        req_valid = 2'b01; req_btn0 = 2'd1;
        #1 chk("x_cross_ready", req_ready, 1);
        cyc(); req_valid = 2'b00;
        #1;
        chk("x_dropped_en", core_en, 0);
        chk("x_still_fight", mode, 1);
        repeat (3) cyc();
        #1 chk("x_no_exit", mode, 1);
        req_valid = 2'b01; req_btn0 = 2'd0;
        #1 chk("x_leave_ready", req_ready, 1);
        cyc(); req_valid = 2'b00;
        #1;
        chk("x_left_mode", mode, 0);
        chk("x_left_en", core_en, 1);
        chk("x_left_btn", core_btn, 0);

        // Reset while locked in REACT, then P1 alone is granted.
        cyc(); req_valid = 2'b01; req_btn0 = 2'd1;
        cyc(); req_valid = 2'b00;
        #1 chk("z_mode_before", mode, 2);
        #1 reset = 1'b0;
        #1;
        chk("z_async_mode", mode, 0);
        chk("z_async_locked", locked, 0);
        chk("z_async_en", core_en, 0);
        chk("z_async_btn", core_btn, 0);
        @(negedge clock);
        cyc(); reset = 1'b1; req_valid = 2'b10; req_btn1 = 2'd2;
        #1 chk("z_p1_ready", req_ready, 2);
        cyc(); req_valid = 2'b00;
        #1;
        chk("z_p1_btn", core_btn, 2);
        chk("z_p1_en", core_en, 1);

        // Randomized traffic; pads hold their button until accepted.
        pv = 2'b00; pb[0] = 2'd0; pb[1] = 2'd0; rate = 2;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            rdy_s = req_ready;
            @(posedge clock);
            #1;
            if (n % 400 == 0) rate = ($urandom % 2 == 0) ? 2 : 9;
            if ($urandom % 600 == 0) begin
                reset = 1'b0;
                pv = 2'b00;
            end else begin
                reset = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && rdy_s[i]) pv[i] = 1'b0;
                if (!pv[i] && ($urandom % rate == 0)) begin
                    pv[i] = 1'b1;
                    pb[i] = 2'($urandom % 4);
                end
            end
            req_valid = pv;
            req_btn0  = pb[0];
            req_btn1  = pb[1];
        end

        reset = 1'b1;
        req_valid = 2'b00;
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_arbiter.md
Name: pad_arbiter

Overview:
- Shares the single gameboy character core between two player pads (P0, P1).
- Each pad issues button presses over a valid/ready handshake; the arbiter forwards one press per cycle as a registered button strobe into the core.
- A pad that puts the core into FIGHT or REACT mode owns the core until it exits that mode or goes idle too long. On idle timeout the arbiter injects the exit press itself.
- The arbiter's mode tracking mirrors the core state machine.

Parameters:
TIMEOUT, 16, consecutive owner-idle cycles in a locked mode before forced exit (min 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  2  bit i = pad i has a press pending
req_btn0  in  2  P0 button code (Fight=0, React=1, A=2, B=3)
req_btn1  in  2  P1 button code
req_ready  out  2  bit i = pad i's press accepted this cycle (combinational)
core_btn  out  2  button code to core x input (registered)
core_en  out  1  one-cycle strobe; core samples core_btn only when high
mode  out  2  mirrored core mode: IDLE=0, FIGHT=1, REACT=2 (registered)
locked  out  1  high while mode != IDLE
owner  out  1  pad holding the lock; valid only when locked

Behaviour:
- Reset (reset=0, async): core_en=0, core_btn=0, mode=IDLE, locked=0, owner=0, round-robin pointer rr=0, idle counter=0, state=ARB. req_ready=0 while in reset.
- Transfer: pad i transfers when req_valid[i] & req_ready[i]. At most one transfer per cycle.
- Forwarded press: core_btn and core_en appear on the next rising edge (1-cycle latency). core_en is high for exactly one cycle per forwarded press. mode, locked and owner update on the same edge.
- State ARB (mode IDLE):
  - If only one pad is valid, grant it.
  - If both are valid, grant pad rr.
  - After any grant, rr <= the other pad.
  - Fight: forward; mode<=FIGHT, locked<=1, owner<=granted pad, state<=LOCK.
  - React: forward; mode<=REACT, locked<=1, owner<=granted pad, state<=LOCK.
  - A/B: forward; mode stays IDLE.
- State LOCK:
  - req_ready is only ever asserted for the owner; the non-owner is held (ready=0).
  - Owner presses its own mode button (Fight in FIGHT, React in REACT): forward; mode<=IDLE, locked<=0, state<=ARB, rr<=non-owner.
  - Owner presses A or B: forward; stay in LOCK.
  - Owner presses the cross-mode button (React in FIGHT, Fight in REACT): accept (ready=1) but drop. core_en stays 0 and the counter is cleared.
- Idle counter (LOCK only):
  - Clears on entry to LOCK and on every owner transfer.
  - Otherwise increments each cycle.
  - A cycle where counter==TIMEOUT-1 with no owner transfer: state<=EXIT.
  - If the owner transfers in that same cycle, the transfer wins and the counter clears.
- State EXIT (one cycle):
  - No pad is ready.
  - At the next edge: core_btn<=mode button, core_en<=1, mode<=IDLE, locked<=0, rr<=non-owner, state<=ARB.
- Counter width is $clog2(TIMEOUT); it never wraps because EXIT intercepts it.
- Reset mid-lock or mid-EXIT returns everything to reset values immediately. The core must share this reset so the mirrored mode stays consistent.
- Requirement on pads: btn must be held stable while valid is high and not ready.
- Assertions:
  - req_ready is one-hot or zero.
  - core_en never high on two consecutive cycles unless two consecutive transfers occurred.

Decomposition:
- Shared package gameboy_pkg holds:
  - button codes (Fight, React, A, B)
  - mode codes (IDLE, FIGHT, REACT)
  - action codes (Kick=000, Punch=001, Jump=010, Duck=011, Run=100)
  - arbiter state enum (ARB, LOCK, EXIT)
- The core and this block both import gameboy_pkg.
- One sub-module, lock_timer: parameter TIMEOUT; inputs clear and run; output expire. It is a counter only; pad_arbiter holds the FSM and the round-robin logic.

Test Plan:
- Reset, then P0 presses A → req_ready=01 in the same cycle; next cycle core_btn=2, core_en=1, mode=0, locked=0.
- Both pads valid with B from reset (rr=0) → P0 granted first, P1 granted the following cycle. core_btn=3 strobes on two consecutive cycles.
- P1 presses Fight, then P0 holds A valid → mode=1, owner=1, and P0 ready stays 0. P1 then presses Fight → mode=0, and P0 is granted on the next cycle.
- TIMEOUT=4: P0 presses React and stays idle → EXIT after 4 cycles; core_btn=1 and core_en=1 on the following edge, mode=0, rr=1.
- TIMEOUT=4: in FIGHT, the owner presses React at counter 3 → accepted and dropped (core_en=0), counter clears, no EXIT.
- Assert reset while locked (mode=2) → outputs and mode return to 0 asynchronously. After release, P1 alone with A valid is granted immediately.
